interleaver_pp_sequencer: RTL
=============================

# interleaver_pp_sequencer

Controller for the two-bank ping-pong bit buffer in front of the 802.16 block interleaver (QPSK, Ncbps = 192, d = 16). It sequences the write side (natural order) and read side (interleaved order) of banks A and B independently with valid/ready handshakes. Buffering therefore continues while the previous block drains. It owns all bank enables, addresses and the output mux select. It sits between the randomizer/FEC output stream and the modulator mapper.

## Interface
- BLOCK_BITS, 192, bits per interleaver block (bank depth)
- D, 16, interleaver column count; ROWS = BLOCK_BITS/D = 12
- ADDR_W, 8, bank address width
- clk  in  1  system clock, rising edge
- resetN  in  1  asynchronous active-low reset
- in_valid  in  1  upstream bit valid
- in_ready  out  1  controller can accept a bit this cycle
- wraddress  out  ADDR_W  write address, shared by both banks
- wren_A / wren_B  out  1  bank write enables, one-hot or zero
- rdaddress  out  ADDR_W  read address, shared by both banks
- rden_A / rden_B  out  1  bank read enables, one-hot or zero
- q_sel  out  1  output mux select: 0 = q_A, 1 = q_B
- out_valid  out  1  selected bank q is a valid interleaved bit
- out_ready  in  1  downstream accepts the bit
- block_done  out  1  one-cycle pulse when the last bit of a block is accepted downstream

## Operation
- Banks have full flags full_A/full_B, both reset to 0. Banks must hold q while rden is low (one-cycle read latency).
- Write sequencer:
  - wr_bank resets to A. in_ready = !full[wr_bank].
  - On in_valid & in_ready: wren[wr_bank] = 1, wraddress = wr_cnt, and wr_cnt increments.
  - At wr_cnt = 191: set full[wr_bank], toggle wr_bank, wr_cnt → 0.
  - wren is low whenever no transfer occurs.
- Read sequencer FSM has two states:
  - RD_IDLE → RD_RUN when full[rd_bank].
  - RD_RUN → RD_IDLE after the read of j = 191 is issued. In the same cycle, clear full[rd_bank] and toggle rd_bank.
- Read issue rule: issue in RD_RUN when (!out_valid | out_ready). rden[rd_bank] = 1, rdaddress = addr(j), and j increments.
- addr(j) = 16·(j mod 12) + floor(j/12). It is generated with no divider by a row counter (0..11) and a col counter (0..15):
  - addr += 16 per read.
  - When row wraps 11 → 0: col++ and addr = col.
  - Sequence: 0, 16, 32 … 176, 1, 17 … 191.
- out_valid is set the cycle after a read is issued. It clears on out_ready when no new read is issued that cycle.
- q_sel is registered from rd_bank at read issue, so it tracks the data currently on q.
- Simultaneous events:
  - Write completing into one bank while the read clears the other is legal; both flag updates apply.
  - A clear and a set of the same flag in one cycle cannot occur (the write side is blocked by that flag).
- Reset mid-operation: all counters, flags and banks return to A and all outputs deassert. Partial blocks are discarded.

## Timing
- Reset values: in_ready = 1; wren_A = wren_B = rden_A = rden_B = 0; wraddress = rdaddress = 0; q_sel = 0; out_valid = 0; block_done = 0.
- in_ready is combinational from registered flags only. There is no combinational path from out_ready to in_ready.
- Latency with continuous in_valid and out_ready:
  - First write at cycle t, last at t+191.
  - full_A visible at t+192; first rden_A at t+192.
  - First out_valid at t+193; last at t+384.
- Throughput is 1 bit/clk on each side. Steady state allows zero write stalls when out_ready is held high.
- With out_ready low, out_valid and q hold and no read is issued. A third block stalls in_ready = 0 once both banks are full.
- block_done fires in the cycle out_valid & out_ready for j = 191.

## Structure
- Package wimax_pkg holds BLOCK_BITS, D and ROWS constants and the bank_t enum {BANK_A, BANK_B}. It also holds the read-state enum {RD_IDLE, RD_RUN}.
- Sub-module interleave_addr_gen holds the row/col/addr counters with clear and step inputs and outputs addr and last. It is reusable for other modulation depths.

## Test plan
- Single block, continuous valid/ready: 192 writes to A at 0..191. First rden_A at cycle 192; rdaddress sequence starts 0, 16, 32 and ends 175, 191. out_valid appears on 192 consecutive cycles and block_done occurs once.
- Back-to-back 3 blocks: the second block is written to B at wraddress 0..191 while A drains. Its read uses q_sel = 1. in_ready never drops.
- out_ready low from cycle 200 for 50 cycles: out_valid holds and rdaddress does not advance. After B fills, in_ready = 0 until A's last read is issued.
- in_valid toggled every other cycle: wraddress advances only on accepted bits. The output order is identical to the continuous case.
- resetN pulsed low at write count 100: all outputs return to reset values asynchronously. The next block is written to A starting at address 0.
- Check j = 11 → 12 wrap: rdaddress 176 → 1. At j = 191, both flags update in the same cycle when a write completes simultaneously.

Source files
------------

// File: rtl/wimax_pkg.sv
// Shared constants and enums for the 802.16 interleaver ping-pong buffer.
// QPSK block: Ncbps = 192 bits, d = 16 columns, 12 rows.
package wimax_pkg;

    localparam int BLOCK_BITS = 192;
    localparam int D          = 16;
    localparam int ROWS       = BLOCK_BITS / D;
    localparam int ADDR_W     = 8;

    typedef enum logic {
        BANK_A = 1'b0,
        BANK_B = 1'b1
    } bank_t;

    typedef enum logic {
        RD_IDLE = 1'b0,
        RD_RUN  = 1'b1
    } rd_state_t;

    function automatic bank_t other_bank(input bank_t b);
        return (b == BANK_A) ? BANK_B : BANK_A;
    endfunction

endpackage

// File: rtl/interleave_addr_gen.sv
// Divider-free row/column address walker: addr = D*row + col,
// stepping down a column before moving to the next one.
module interleave_addr_gen #(
    parameter int ROWS   = 12,
    parameter int D      = 16,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              resetN,
    input  logic              clear_i,
    input  logic              step_i,
    output logic [ADDR_W-1:0] addr_o,
    output logic              last_o
);

    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int CW = (D > 1) ? $clog2(D) : 1;

    localparam logic [RW-1:0]     ROW_MAX = RW'(ROWS - 1);
    localparam logic [CW-1:0]     COL_MAX = CW'(D - 1);
    localparam logic [ADDR_W-1:0] STRIDE  = ADDR_W'(D);

    logic [RW-1:0]     row_q, row_d;
    logic [CW-1:0]     col_q, col_d;
    logic [ADDR_W-1:0] addr_q, addr_d;

    always_comb begin
        row_d  = row_q;
        col_d  = col_q;
        addr_d = addr_q;
        if (clear_i) begin
            row_d  = '0;
            col_d  = '0;
            addr_d = '0;
        end else if (step_i) begin
            if (row_q == ROW_MAX) begin
                // Column finished: restart at the top of the next column.
                row_d  = '0;
                col_d  = (col_q == COL_MAX) ? '0 : col_q + CW'(1);
                addr_d = ADDR_W'(col_d);
            end else begin
                row_d  = row_q + RW'(1);
                addr_d = addr_q + STRIDE;
            end
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            row_q  <= '0;
            col_q  <= '0;
            addr_q <= '0;
        end else begin
            row_q  <= row_d;
            col_q  <= col_d;
            addr_q <= addr_d;
        end
    end

    assign addr_o = addr_q;
    assign last_o = (row_q == ROW_MAX) && (col_q == COL_MAX);

endmodule

// File: rtl/interleaver_pp_sequencer.sv
// Ping-pong bank controller: natural-order writes, interleaved-order reads,
// each side with its own valid/ready handshake and bank pointer.
module interleaver_pp_sequencer #(
    parameter int BLOCK_BITS = 192,
    parameter int D          = 16,
    parameter int ADDR_W     = 8
) (
    input  logic              clk,
    input  logic              resetN,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [ADDR_W-1:0] wraddress,
    output logic              wren_A,
    output logic              wren_B,
    output logic [ADDR_W-1:0] rdaddress,
    output logic              rden_A,
    output logic              rden_B,
    output logic              q_sel,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              block_done
);

    import wimax_pkg::*;

    localparam int ROWS = BLOCK_BITS / D;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(BLOCK_BITS - 1);

    bank_t             wr_bank_q, wr_bank_d;
    bank_t             rd_bank_q, rd_bank_d;
    rd_state_t         rd_state_q, rd_state_d;
    logic [1:0]        full_q, full_d;
    logic [ADDR_W-1:0] wr_cnt_q, wr_cnt_d;
    logic              out_valid_q, out_valid_d;
    logic              q_sel_q, q_sel_d;
    logic              last_q, last_d;

    logic              wr_fire;
    logic              wr_last;
    logic              rd_issue;
    logic              rd_last;
    logic              ag_last;
    logic [ADDR_W-1:0] ag_addr;

    // Write side
    assign in_ready  = !full_q[wr_bank_q];
    assign wr_fire   = in_valid && in_ready;
    assign wr_last   = wr_fire && (wr_cnt_q == LAST_ADDR);
    assign wraddress = wr_cnt_q;
    assign wren_A    = wr_fire && (wr_bank_q == BANK_A);
    assign wren_B    = wr_fire && (wr_bank_q == BANK_B);

    always_comb begin
        wr_cnt_d  = wr_cnt_q;
        wr_bank_d = wr_bank_q;
        if (wr_last) begin
            wr_cnt_d  = '0;
            wr_bank_d = other_bank(wr_bank_q);
        end else if (wr_fire) begin
            wr_cnt_d = wr_cnt_q + ADDR_W'(1);
        end
    end

    // Read side: a freshly filled bank is read in the same cycle it shows full.
    always_comb begin
        rd_state_d = rd_state_q;
        rd_issue   = 1'b0;
        unique case (rd_state_q)
            RD_IDLE: begin
                if (full_q[rd_bank_q]) begin
                    rd_state_d = RD_RUN;
                    rd_issue   = !out_valid_q || out_ready;
                end
            end
            RD_RUN: begin
                rd_issue = !out_valid_q || out_ready;
            end
            default: rd_state_d = RD_IDLE;
        endcase
        rd_last = rd_issue && ag_last;
        if (rd_last) begin
            rd_state_d = RD_IDLE;
        end
    end

    always_comb begin
        rd_bank_d   = rd_last ? other_bank(rd_bank_q) : rd_bank_q;
        out_valid_d = rd_issue ? 1'b1 : (out_ready ? 1'b0 : out_valid_q);
        q_sel_d     = rd_issue ? (rd_bank_q == BANK_B) : q_sel_q;
        last_d      = rd_issue ? ag_last : last_q;
    end

    // Set and clear always target different banks, so both may apply.
    always_comb begin
        full_d = full_q;
        if (wr_last) begin
            full_d[wr_bank_q] = 1'b1;
        end
        if (rd_last) begin
            full_d[rd_bank_q] = 1'b0;
        end
    end

    interleave_addr_gen #(
        .ROWS   (ROWS),
        .D      (D),
        .ADDR_W (ADDR_W)
    ) u_addr_gen (
        .clk     (clk),
        .resetN  (resetN),
        .clear_i (rd_last),
        .step_i  (rd_issue),
        .addr_o  (ag_addr),
        .last_o  (ag_last)
    );

    assign rdaddress  = ag_addr;
    assign rden_A     = rd_issue && (rd_bank_q == BANK_A);
    assign rden_B     = rd_issue && (rd_bank_q == BANK_B);
    assign q_sel      = q_sel_q;
    assign out_valid  = out_valid_q;
    assign block_done = out_valid_q && out_ready && last_q;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            wr_bank_q   <= BANK_A;
            rd_bank_q   <= BANK_A;
            rd_state_q  <= RD_IDLE;
            full_q      <= '0;
            wr_cnt_q    <= '0;
            out_valid_q <= 1'b0;
            q_sel_q     <= 1'b0;
            last_q      <= 1'b0;
        end else begin
            wr_bank_q   <= wr_bank_d;
            rd_bank_q   <= rd_bank_d;
            rd_state_q  <= rd_state_d;
            full_q      <= full_d;
            wr_cnt_q    <= wr_cnt_d;
            out_valid_q <= out_valid_d;
            q_sel_q     <= q_sel_d;
            last_q      <= last_d;
        end
    end

endmodule
